// File: rtl/pipelined_addsub_if.sv
// Stream bundle for the segmented adder/subtractor: operand beat in, result beat out.
interface pipelined_addsub_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Segmented-carry pipelined adder/subtractor. Stage k adds segment k of the
// (possibly inverted) operands using the carry registered by stage k-1; upper
// operand segments ride along untouched and finished low segments are delayed
// so the full result emerges aligned. One global stall freezes every stage.
module pipelined_addsub #(
  parameter int W   = 32,
  parameter int SEG = 4
) (
  input logic             clk,
  input logic             rst,
  pipelined_addsub_if.slave bus
);
  localparam int G = W / SEG;

  logic           adv;
  logic [W-1:0]   a_eff, b_eff;
  logic           c_eff;

  // Stage registers; index k is the output of stage k.
  logic [W-1:0]   a_q [SEG];
  logic [W-1:0]   b_q [SEG];
  logic [W-1:0]   s_q [SEG];
  logic [SEG-1:0] cy_q;
  logic [SEG-1:0] vld_q;
  logic           ovf_q, zero_q;

  // Stage inputs and combinational next values.
  logic [W-1:0]   a_in [SEG];
  logic [W-1:0]   b_in [SEG];
  logic [W-1:0]   s_in [SEG];
  logic [W-1:0]   s_n  [SEG];
  logic [SEG-1:0] cy_n;
  logic [G:0]     t;
  logic           ovf_n, zero_n;

  // vld_pipe[k] / cy_pipe[k] are the valid and carry entering stage k;
  // index SEG is the output of the last stage.
  logic [SEG:0]   vld_pipe;
  logic [SEG:0]   cy_pipe;

  // Subtract folds into add: a + ~b + ~c_in.
  assign a_eff    = bus.a;
  assign b_eff    = bus.b ^ {W{bus.sub}};
  assign c_eff    = bus.c_in ^ bus.sub;

  assign adv      = !vld_q[SEG-1] || bus.out_ready;
  assign vld_pipe = {vld_q, bus.in_valid};
  assign cy_pipe  = {cy_q, c_eff};

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[SEG-1];
  assign bus.s         = s_q[SEG-1];
  assign bus.c_out     = cy_q[SEG-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  // Per-stage segment add and final-stage flag derivation.
  always_comb begin
    t      = '0;
    cy_n   = '0;
    a_in[0] = a_eff;
    b_in[0] = b_eff;
    s_in[0] = '0;
    for (int k = 1; k < SEG; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
    end
    for (int k = 0; k < SEG; k++) begin
      t = {1'b0, a_in[k][k*G +: G]} + {1'b0, b_in[k][k*G +: G]} + {{G{1'b0}}, cy_pipe[k]};
      s_n[k] = s_in[k];
      s_n[k][k*G +: G] = t[G-1:0];
      cy_n[k] = t[G];
    end
    // Sign-based overflow on the effective operands seen by the top segment.
    ovf_n  = (a_in[SEG-1][W-1] == b_in[SEG-1][W-1]) && (s_n[SEG-1][W-1] != a_in[SEG-1][W-1]);
    zero_n = (s_n[SEG-1] == '0);
  end

  // Advance all stages together; data only loads where a real beat arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < SEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_pipe[SEG-1:0];
      for (int k = 0; k < SEG; k++) begin
        if (vld_pipe[k]) begin
          a_q[k]  <= a_in[k];
          b_q[k]  <= b_in[k];
          s_q[k]  <= s_n[k];
          cy_q[k] <= cy_n[k];
        end
      end
      if (vld_pipe[SEG-1]) begin
        ovf_q  <= ovf_n;
        zero_q <= zero_n;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench: W=8/SEG=2 directed cases, plus a shared 16-beat sweep with a 3-cycle
// stall driven into W=32 SEG=1 and SEG=8 instances alongside, and a mid-stream
// asynchronous reset.
module tb_pipelined_addsub;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, c_in, sub;
  logic [31:0] a, b;

  int checks = 0;
  int errors = 0;

  logic [34:0] q_a [$];
  logic [34:0] q_b [$];
  logic [34:0] q_c [$];

  pipelined_addsub_if #(.W(8))  bus_a ();
  pipelined_addsub_if #(.W(32)) bus_b ();
  pipelined_addsub_if #(.W(32)) bus_c ();

  assign bus_a.in_valid = in_valid;  assign bus_a.out_ready = out_ready;
  assign bus_a.a = a[7:0];           assign bus_a.b = b[7:0];
  assign bus_a.c_in = c_in;          assign bus_a.sub = sub;
  assign bus_b.in_valid = in_valid;  assign bus_b.out_ready = out_ready;
  assign bus_b.a = a;                assign bus_b.b = b;
  assign bus_b.c_in = c_in;          assign bus_b.sub = sub;
  assign bus_c.in_valid = in_valid;  assign bus_c.out_ready = out_ready;
  assign bus_c.a = a;                assign bus_c.b = b;
  assign bus_c.c_in = c_in;          assign bus_c.sub = sub;

  pipelined_addsub #(.W(8),  .SEG(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  pipelined_addsub #(.W(32), .SEG(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  pipelined_addsub #(.W(32), .SEG(8)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Full-width reference: {zero, ovf, c_out, s} for a w-bit add/sub.
  function automatic logic [34:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic sb);
    logic [32:0] full;
    logic [31:0] mask, bb, r;
    logic        co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    bb   = (y ^ {32{sb}}) & mask;
    full = {1'b0, x & mask} + {1'b0, bb} + {32'd0, ci ^ sb};
    r    = full[31:0] & mask;
    co   = full[w];
    ov   = (x[w-1] == bb[w-1]) && (r[w-1] != x[w-1]);
    return {(r == 32'd0), ov, co, r};
  endfunction

  // Result monitors: a consumption happens on the edge after a negedge
  // where out_valid && out_ready.
  always @(negedge clk) if (!rst && bus_a.out_valid && bus_a.out_ready) begin
    if (q_a.size() == 0) chk("s2 spurious", 64'(bus_a.s), 64'hDEAD);
    else chk("s2 result", 64'({bus_a.zero, bus_a.ovf, bus_a.c_out, 24'd0, bus_a.s}), 64'(q_a.pop_front()));
  end
  always @(negedge clk) if (!rst && bus_b.out_valid && bus_b.out_ready) begin
    if (q_b.size() == 0) chk("s1 spurious", 64'(bus_b.s), 64'hDEAD);
    else chk("s1 result", 64'({bus_b.zero, bus_b.ovf, bus_b.c_out, bus_b.s}), 64'(q_b.pop_front()));
  end
  always @(negedge clk) if (!rst && bus_c.out_valid && bus_c.out_ready) begin
    if (q_c.size() == 0) chk("s8 spurious", 64'(bus_c.s), 64'hDEAD);
    else chk("s8 result", 64'({bus_c.zero, bus_c.ovf, bus_c.c_out, bus_c.s}), 64'(q_c.pop_front()));
  end

  // Present one beat (entered just after a posedge), wait for acceptance,
  // return just after the accepting edge.
  task automatic put(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb,
                     input logic [34:0] exp8);
    int n;
    a = x; b = y; c_in = ci; sub = sb; in_valid = 1'b1;
    q_a.push_back(exp8);
    q_b.push_back(model(32, x, y, ci, sb));
    q_c.push_back(model(32, x, y, ci, sb));
    n = 0;
    @(negedge clk);
    while (!bus_a.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n == 50) chk("accept timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);
  endtask

  task automatic reset_state(input string tag);
    chk({tag, " s2"}, 64'({bus_a.in_ready, bus_a.out_valid, bus_a.zero, bus_a.ovf, bus_a.c_out, bus_a.s}),
        64'({1'b1, 12'd0}));
    chk({tag, " s1"}, 64'({bus_b.in_ready, bus_b.out_valid, bus_b.zero, bus_b.ovf, bus_b.c_out, bus_b.s}),
        64'({1'b1, 36'd0}));
    chk({tag, " s8"}, 64'({bus_c.in_ready, bus_c.out_valid, bus_c.zero, bus_c.ovf, bus_c.c_out, bus_c.s}),
        64'({1'b1, 36'd0}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [34:0] hold_a, hold_b, hold_c;
    logic [31:0] x, y;
    logic        ci, sb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #1 reset_state("reset");
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // Signed overflow, plus latency: SEG=2 valid after the 2nd edge
    // counting the accepting edge, SEG=1 right after the accepting edge.
    put(32'h7F, 32'h01, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h80});
    chk("lat s2 edge1", 64'(bus_a.out_valid), 64'd0);
    chk("lat s1 edge1", 64'(bus_b.out_valid), 64'd1);
    @(posedge clk); #1;
    chk("lat s2 edge2", 64'(bus_a.out_valid), 64'd1);
    drain();

    // Inter-segment carry, back-to-back.
    put(32'h0F, 32'h01, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h10});
    put(32'hFF, 32'h01, 1'b1, 1'b0, {1'b0, 1'b0, 1'b1, 32'h01});
    drain();

    // Subtract equal operands.
    put(32'h05, 32'h05, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 32'h00});
    drain();

    // Subtract with borrow in/out.
    put(32'h00, 32'h01, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFF});
    put(32'h10, 32'h01, 1'b1, 1'b1, {1'b0, 1'b0, 1'b1, 32'h0E});
    drain();

    // Random sweep with a 3-cycle downstream stall after 10 accepts.
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          x = $urandom; y = $urandom;
          ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
          put(x, y, ci, sb, model(8, x, y, ci, sb));
        end
      end
      begin
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall in_ready", 64'({bus_a.in_ready, bus_b.in_ready, bus_c.in_ready}), 64'd0);
          if (i == 0) begin
            hold_a = {bus_a.zero, bus_a.ovf, bus_a.c_out, 24'd0, bus_a.s};
            hold_b = {bus_b.zero, bus_b.ovf, bus_b.c_out, bus_b.s};
            hold_c = {bus_c.zero, bus_c.ovf, bus_c.c_out, bus_c.s};
          end else begin
            chk("hold s2", 64'({bus_a.out_valid, bus_a.zero, bus_a.ovf, bus_a.c_out, 24'd0, bus_a.s}),
                64'({1'b1, hold_a}));
            chk("hold s1", 64'({bus_b.out_valid, bus_b.zero, bus_b.ovf, bus_b.c_out, bus_b.s}),
                64'({1'b1, hold_b}));
            chk("hold s8", 64'({bus_c.out_valid, bus_c.zero, bus_c.ovf, bus_c.c_out, bus_c.s}),
                64'({1'b1, hold_c}));
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("release in_ready", 64'({bus_a.in_ready, bus_b.in_ready, bus_c.in_ready}), 64'h7);
      end
    join
    drain();

    // Asynchronous reset with two beats in flight; they must never appear.
    put(32'h12, 32'h34, 1'b0, 1'b0, model(8, 32'h12, 32'h34, 1'b0, 1'b0));
    put(32'h56, 32'h78, 1'b1, 1'b1, model(8, 32'h56, 32'h78, 1'b1, 1'b1));
    rst = 1'b1;
    q_a.delete(); q_b.delete(); q_c.delete();
    #1 reset_state("midrst");
    #1 rst = 1'b0;
    put(32'h33, 32'h44, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h77});
    chk("post-rst edge1", 64'(bus_a.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("post-rst edge2", 64'({bus_a.out_valid, bus_a.s}), 64'({1'b1, 8'h77}));
    drain();
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
